// File: rtl/pulse_fil_pkg.sv
// pulse_fil_pkg: shared widths, coefficient limits and
// config-sequencer state encoding for the pulse_fil family.
package pulse_fil_pkg;

  localparam int DEF_FILTER_COUNTER_WIDTH = 22;
  localparam int DEF_MIN_COEFF            = 4;
  localparam int DEF_DEFAULT_COEFF        = 200000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    APPLY = ST_APPLY,
    DONE  = ST_DONE
  } cfg_state_t;

  // bits needed to count 0..n-1, never less than one
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_fil_cfg_timeout.sv
// pulse_fil_cfg_timeout: per-channel wait counter of the
// config sequencer; flags when a channel waited too long.
module pulse_fil_cfg_timeout
  import pulse_fil_pkg::*;
#(
  parameter int TIMEOUT = 4000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // count waited cycles, holding at the last one until cleared
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/pulse_fil_cfg_ctrl.sv
// pulse_fil_cfg_ctrl: shadow/active coefficient banks and the
// commit sequencer that applies each channel when it is quiet.
module pulse_fil_cfg_ctrl
  import pulse_fil_pkg::*;
#(
  parameter int N_CH                 = 4,
  parameter int FILTER_COUNTER_WIDTH = DEF_FILTER_COUNTER_WIDTH,
  parameter int MIN_COEFF            = DEF_MIN_COEFF,
  parameter int DEFAULT_COEFF        = DEF_DEFAULT_COEFF,
  parameter int TIMEOUT              = 4000000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [3:0]                        cfg_chan,
  input  logic [FILTER_COUNTER_WIDTH-1:0]   cfg_coeff,
  output logic                              cfg_err,
  input  logic                              commit,
  output logic                              busy,
  output logic                              commit_done,
  output logic [N_CH-1:0]                   forced,
  input  logic [N_CH-1:0]                   fil_in_sync,
  input  logic [N_CH-1:0]                   fil_out,
  output logic [N_CH*FILTER_COUNTER_WIDTH-1:0] coeff_bus
);

  localparam int W  = FILTER_COUNTER_WIDTH;
  localparam int IW = cnt_width(N_CH);
  localparam logic [W-1:0]  MINV     = W'(MIN_COEFF);
  localparam logic [W-1:0]  DEFV     = W'(DEFAULT_COEFF);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

  cfg_state_t    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  shadow [N_CH];
  logic [W-1:0]  active [N_CH];

  logic         fire;
  logic         chan_ok;
  logic [W-1:0] wr_val;
  logic         quiet;
  logic         expired;
  logic         apply;
  logic         tmo_clear;
  logic         tmo_en;

  assign fire    = cfg_valid && cfg_ready;
  assign chan_ok = ({1'b0, cfg_chan} < 5'(N_CH));
  assign wr_val  = (cfg_coeff < MINV) ? MINV : cfg_coeff;

  // a channel is quiet when its filter output already tracks its input
  assign quiet = (fil_in_sync[idx] == fil_out[idx]);
  assign apply = (state == APPLY) && (quiet || expired);

  assign tmo_clear = (state != APPLY) || apply;
  assign tmo_en    = (state == APPLY) && !quiet;

  pulse_fil_cfg_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .en      (tmo_en),
    .expired (expired)
  );

  // host writes: clamp into the shadow bank, flag bad channels
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) shadow[k] <= DEFV;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= fire && !chan_ok;
      for (int k = 0; k < N_CH; k++) begin
        if (fire && cfg_chan == 4'(k)) shadow[k] <= wr_val;
      end
    end
  end

  // commit sequencer: walk channels, copy shadow to active
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      commit_done <= 1'b0;
      forced      <= '0;
      for (int k = 0; k < N_CH; k++) active[k] <= DEFV;
    end else begin
      commit_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (commit) begin
            state     <= APPLY;
            idx       <= '0;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        APPLY: begin
          if (apply) begin
            for (int k = 0; k < N_CH; k++) begin
              if (idx == IW'(k)) begin
                active[k] <= shadow[k];
                forced[k] <= !quiet;
              end
            end
            if (idx == LAST_IDX) state <= DONE;
            else idx <= idx + IW'(1);
          end
        end
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          cfg_ready   <= 1'b1;
          commit_done <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_bus
    assign coeff_bus[k*W +: W] = active[k];
  end

endmodule

// File: tb/tb_pulse_fil_cfg_ctrl.sv
// tb_pulse_fil_cfg_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the commit sequence.
module tb_pulse_fil_cfg_ctrl;

  localparam int N    = 4;
  localparam int W    = 22;
  localparam int T    = 100;
  localparam int DEF  = 200000;
  localparam int MINC = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [3:0]     cfg_chan;
  logic [W-1:0]   cfg_coeff;
  logic           cfg_err;
  logic           commit;
  logic           busy;
  logic           commit_done;
  logic [N-1:0]   forced;
  logic [N-1:0]   fil_in_sync;
  logic [N-1:0]   fil_out;
  logic [N*W-1:0] coeff_bus;

  int n_tests = 0;
  int n_fail  = 0;

  always #25 clk = ~clk;

  pulse_fil_cfg_ctrl #(
    .N_CH    (N),
    .TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_coeff   (cfg_coeff),
    .cfg_err     (cfg_err),
    .commit      (commit),
    .busy        (busy),
    .commit_done (commit_done),
    .forced      (forced),
    .fil_in_sync (fil_in_sync),
    .fil_out     (fil_out),
    .coeff_bus   (coeff_bus)
  );

  // behavioural model: m_ph = -1 idle, 0..N-1 channel being
  // applied, N = the one wrap-up cycle before commit_done
  int       m_sh [N];
  int       m_ac [N];
  bit [N-1:0] m_fo;
  bit       m_rdy = 1'b1;
  bit       m_bsy, m_dn, m_er;
  int       m_ph = -1;
  int       m_wt;
  bit       chk_en = 1'b0;

  always @(posedge clk) begin
    bit fire;
    bit q;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_sh[k] = DEF;
        m_ac[k] = DEF;
      end
      m_fo = '0; m_rdy = 1; m_bsy = 0;
      m_dn = 0; m_er = 0; m_ph = -1; m_wt = 0;
    end else begin
      fire = cfg_valid && m_rdy;
      m_er = fire && (cfg_chan >= N);
      m_dn = 0;
      if (m_ph < 0) begin
        if (fire && cfg_chan < N)
          m_sh[cfg_chan] = (cfg_coeff < MINC) ? MINC : int'(cfg_coeff);
        if (commit) begin
          m_ph = 0; m_wt = 0; m_bsy = 1; m_rdy = 0;
        end
      end else if (m_ph < N) begin
        q = (fil_in_sync[m_ph] == fil_out[m_ph]);
        if (q || m_wt == T - 1) begin
          m_ac[m_ph] = m_sh[m_ph];
          m_fo[m_ph] = !q;
          m_ph++;
          m_wt = 0;
        end else begin
          m_wt++;
        end
      end else begin
        m_ph = -1; m_bsy = 0; m_rdy = 1; m_dn = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++)
        chk($sformatf("model coeff[%0d]", k),
            64'(coeff_bus[k*W +: W]), 64'(m_ac[k]));
      chk("model cfg_ready", 64'(cfg_ready), 64'(m_rdy));
      chk("model busy", 64'(busy), 64'(m_bsy));
      chk("model commit_done", 64'(commit_done), 64'(m_dn));
      chk("model cfg_err", 64'(cfg_err), 64'(m_er));
      chk("model forced", 64'(forced), 64'(m_fo));
    end
  end

  function automatic logic [W-1:0] slice(input int k);
    return coeff_bus[k*W +: W];
  endfunction

  task automatic wr(input int c, input int v);
    cfg_valid = 1'b1;
    cfg_chan  = 4'(c);
    cfg_coeff = W'(v);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // lat = edges from the commit edge to the commit_done cycle
  task automatic run_commit(input int limit, output int lat);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    lat = 0;
    while (!commit_done && lat < limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int  lat;
  bit  rdy_prev;
  int  mode [N];

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_chan = '0;
    cfg_coeff = '0; commit = 1'b0;
    fil_in_sync = '0; fil_out = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // reset state
    for (int k = 0; k < N; k++)
      chk($sformatf("reset coeff[%0d]", k), 64'(slice(k)), 64'(DEF));
    chk("reset cfg_ready", 64'(cfg_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset forced", 64'(forced), 64'd0);

    // single write, all quiet
    wr(2, 1000);
    run_commit(50, lat);
    chk("quiet latency", 64'(lat), 64'(N + 1));
    chk("ch2 applied", 64'(slice(2)), 64'd1000);
    chk("ch0 untouched", 64'(slice(0)), 64'(DEF));
    @(negedge clk);
    chk("done one cycle", 64'(commit_done), 64'd0);

    // clamp and out-of-range write
    wr(1, 2);
    wr(7, 5);
    chk("err pulse", 64'(cfg_err), 64'd1);
    chk("ready after err", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    chk("err cleared", 64'(cfg_err), 64'd0);
    run_commit(50, lat);
    chk("clamp latency", 64'(lat), 64'(N + 1));
    chk("ch1 clamped", 64'(slice(1)), 64'(MINC));
    chk("ch3 no bad write", 64'(slice(3)), 64'(DEF));

    // ch0 busy for 50 cycles, then goes quiet
    wr(0, 777);
    commit = 1'b1;
    fil_in_sync[0] = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    lat = 0;
    repeat (50) begin
      @(negedge clk);
      lat++;
    end
    chk("ch0 held while noisy", 64'(slice(0)), 64'(DEF));
    chk("busy while noisy", 64'(busy), 64'd1);
    fil_in_sync[0] = 1'b0;
    while (!commit_done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("late quiet latency", 64'(lat), 64'(50 + N + 1));
    chk("ch0 late apply", 64'(slice(0)), 64'd777);
    chk("ch0 not forced", 64'(forced[0]), 64'd0);

    // ch3 never quiet: forced by timeout
    wr(3, 3333);
    fil_in_sync[3] = 1'b1;
    run_commit(400, lat);
    chk("timeout latency", 64'(lat), 64'(N + T));
    chk("ch3 forced", 64'(forced[3]), 64'd1);
    chk("ch3 forced value", 64'(slice(3)), 64'd3333);
    chk("ch0 still quiet", 64'(forced[0]), 64'd0);
    fil_in_sync[3] = 1'b0;

    // reset in the middle of a sequence
    wr(0, 11);
    wr(1, 22);
    wr(2, 33);
    fil_in_sync[2] = 1'b1;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    repeat (10) @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk("second commit busy", 64'(busy), 64'd1);
    chk("second commit ready", 64'(cfg_ready), 64'd0);
    chk("ch0 applied pre-reset", 64'(slice(0)), 64'd11);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fil_in_sync[2] = 1'b0;
    for (int k = 0; k < N; k++)
      chk($sformatf("midreset coeff[%0d]", k), 64'(slice(k)), 64'(DEF));
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset forced", 64'(forced), 64'd0);
    run_commit(50, lat);
    chk("post-reset latency", 64'(lat), 64'(N + 1));
    chk("post-reset ch0", 64'(slice(0)), 64'(DEF));

    // random traffic against the model
    rdy_prev = cfg_ready;
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < N; c++) mode[c] = $urandom_range(0, 3);
      repeat (120) begin
        @(negedge clk);
        rst_n = ($urandom_range(0, 599) != 0);
        if (!(cfg_valid && !rdy_prev)) begin
          cfg_valid = ($urandom_range(0, 2) == 0);
          cfg_chan  = ($urandom_range(0, 4) == 0) ?
                      4'($urandom_range(4, 15)) :
                      4'($urandom_range(0, 3));
          cfg_coeff = ($urandom_range(0, 1) == 0) ?
                      W'($urandom_range(0, 8)) : W'($urandom);
        end
        rdy_prev = cfg_ready;
        commit = ($urandom_range(0, 24) == 0);
        for (int c = 0; c < N; c++) begin
          case (mode[c])
            0: begin
              fil_out[c]     = 1'($urandom_range(0, 1));
              fil_in_sync[c] = fil_out[c];
            end
            1: begin
              fil_out[c]     = 1'($urandom_range(0, 1));
              fil_in_sync[c] = 1'($urandom_range(0, 1));
            end
            2: begin
              fil_out[c]     = 1'b0;
              fil_in_sync[c] = 1'b1;
            end
            default: begin
              fil_out[c]     = 1'b0;
              fil_in_sync[c] = ($urandom_range(0, 7) == 0);
            end
          endcase
        end
      end
    end
    cfg_valid = 1'b0;
    commit = 1'b0;
    rst_n = 1'b1;
    fil_in_sync = '0;
    fil_out = '0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
